image_dump_engine: RTL

IMAGE_DUMP_ENGINE -- requirements
Module: image_dump_engine

---
 rtl/mem_map_pkg.sv | 21 ++
 rtl/image_dump_engine_if.sv | 24 ++
 rtl/image_dump_engine.sv | 96 +++++++++
 3 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory map and dump-engine state encoding, common to the memory
// controller and the image dump engine.
package mem_map_pkg;

    localparam int unsigned ROM_BASE  = 0;
    localparam int unsigned ROM_LAST  = 152099;
    localparam int unsigned RAM_BASE  = 152100;
    localparam int unsigned RAM_LAST  = 304455;
    localparam int unsigned IMG_WORDS = 152100;

    localparam int unsigned IDX_W = 18;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } dump_state_e;

endpackage

// File: rtl/image_dump_engine_if.sv
// Memory-controller read port plus downstream byte stream of the dump engine.
interface image_dump_engine_if;

    logic        start;
    logic        bus_own;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, mem_rd, tx_ready,
        output bus_own, mem_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, mem_rd, tx_ready,
        input  bus_own, mem_addr, tx_data, tx_valid, busy, done
    );

endinterface

// File: rtl/image_dump_engine.sv
// Streams NUM_WORDS low bytes from memory starting at BASE_ADDR, one
// fetch/send/advance triple per word, with a valid/ready output handshake.
module image_dump_engine
    import mem_map_pkg::*;
#(
    parameter int unsigned BASE_ADDR = RAM_BASE,
    parameter int unsigned NUM_WORDS = IMG_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    image_dump_engine_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [31:0]      BASE_W   = 32'(BASE_ADDR);

    dump_state_e      state_q;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       tx_data_q;
    logic             tx_valid_q;
    logic             bus_own_q;
    logic [31:0]      mem_addr_q;
    logic             busy_q;
    logic             done_q;

    // Outputs are registered, so each transition loads the values the
    // destination state must present during its own cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            bus_own_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= FETCH;
                        idx_q      <= '0;
                        bus_own_q  <= 1'b1;
                        mem_addr_q <= BASE_W;
                        busy_q     <= 1'b1;
                    end
                end
                FETCH: begin
                    tx_data_q  <= bus.mem_rd[7:0];
                    tx_valid_q <= 1'b1;
                    bus_own_q  <= 1'b0;
                    mem_addr_q <= '0;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= NEXT;
                    end
                end
                NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q      <= idx_q + 1'b1;
                        bus_own_q  <= 1'b1;
                        mem_addr_q <= BASE_W + {{(32-IDX_W){1'b0}}, idx_q + 1'b1};
                        state_q    <= FETCH;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    bus_own_q  <= 1'b0;
                    mem_addr_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_own  = bus_own_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule
